// File: rtl/svc_ctrl_pkg.sv
// Shared types, constants and switch-vector helpers for the service arbiter.
package svc_ctrl_pkg;

  localparam int DEF_NUM_SVC = 4;
  localparam int MAX_SVC     = 8;
  localparam int MAX_ID_W    = 3;

  localparam logic [15:0] SEG_BLANK = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } svc_state_t;

  function automatic logic f_multi_hot(input logic [MAX_SVC-1:0] v);
    return (v & (v - MAX_SVC'(1))) != '0;
  endfunction

  function automatic logic f_one_hot(input logic [MAX_SVC-1:0] v);
    return (v != '0) && !f_multi_hot(v);
  endfunction

  function automatic logic [MAX_ID_W-1:0] f_lowest_idx(input logic [MAX_SVC-1:0] v);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SVC - 1; i >= 0; i--) begin
      if (v[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/service_arbiter_ctrl_push_debouncer.sv
// push_debouncer: 2-FF synchronizer, stability counter and one-cycle pulse on an
// accepted high-to-low transition of an active-low button.
module push_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fall;

  // NOTE: every register here uses <= so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_fall  <= r_level & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/service_arbiter_ctrl.sv
// Grants one service at a time from the switch bank, gates its enable, routes push
// events and muxes its segment word. PRIORITY_GRANT_EN: grant lowest index on conflict.
module service_arbiter_ctrl
  import svc_ctrl_pkg::*;
#(
  parameter int NUM_SVC         = DEF_NUM_SVC,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FINISH_TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SVC-1:0]         spdt,
  input  logic                       push_m,
  input  logic [16*NUM_SVC-1:0]      svc_seg,
  input  logic [NUM_SVC-1:0]         svc_finish,
  output logic [NUM_SVC-1:0]         svc_enable,
  output logic [NUM_SVC-1:0]         push_pulse,
  output logic [15:0]                seg_out,
  output logic [$clog2(NUM_SVC)-1:0] active_id,
  output logic                       conflict,
  output logic                       timeout_err
);

  localparam int ID_W   = $clog2(NUM_SVC);
  localparam int WAIT_W = $clog2(FINISH_TIMEOUT + 1);

  svc_state_t         r_state;
  logic [NUM_SVC-1:0] r_spdt_m;
  logic [NUM_SVC-1:0] r_spdt_s;
  logic [ID_W-1:0]    r_active_id;
  logic [NUM_SVC-1:0] r_enable;
  logic [NUM_SVC-1:0] r_push_pulse;
  logic [15:0]        r_seg;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_timeout_err;

  logic [MAX_SVC-1:0] w_sw_ext;
  logic [NUM_SVC-1:0] w_id_dec;
  logic               w_push_evt;
  logic [15:0]        w_seg_arr [NUM_SVC];

  for (genvar g = 0; g < NUM_SVC; g++) begin : g_seg
    assign w_seg_arr[g] = svc_seg[16*g +: 16];
  end

  assign w_sw_ext = MAX_SVC'(r_spdt_s);
  assign w_id_dec = NUM_SVC'(1) << r_active_id;

  push_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_push_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn_n (push_m),
    .o_fall  (w_push_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_spdt_m      <= '0;
      r_spdt_s      <= '0;
      r_active_id   <= '0;
      r_enable      <= '0;
      r_push_pulse  <= '0;
      r_seg         <= SEG_BLANK;
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_spdt_m <= spdt;
      r_spdt_s <= r_spdt_m;
      // A push seen on the last ACTIVE cycle is still delivered to the owner.
      r_push_pulse <= (r_state == ST_ACTIVE && w_push_evt) ? w_id_dec : '0;

      case (r_state)
        ST_IDLE: begin
          r_seg    <= SEG_BLANK;
          r_enable <= '0;
`ifdef PRIORITY_GRANT_EN
          if (w_sw_ext != '0) begin
`else
          if (f_one_hot(w_sw_ext)) begin
`endif
            r_active_id <= ID_W'(f_lowest_idx(w_sw_ext));
            r_state     <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          r_enable <= w_id_dec;
          r_state  <= ST_ACTIVE;
        end

        ST_ACTIVE: begin
          r_seg <= w_seg_arr[r_active_id];
          if (!r_spdt_s[r_active_id]) begin
            r_enable <= '0;
            r_wait   <= '0;
            r_state  <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (svc_finish[r_active_id]) begin
            r_state <= ST_IDLE;
          end else if (r_wait == WAIT_W'(FINISH_TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign svc_enable  = r_enable;
  assign push_pulse  = r_push_pulse;
  assign seg_out     = r_seg;
  assign active_id   = r_active_id;
  assign conflict    = f_multi_hot(w_sw_ext);
  assign timeout_err = r_timeout_err;

endmodule
